// File: rtl/mcy_mutsel_ctrl.sv
// rtl/mcy_mutsel_ctrl.sv - multi-channel timed mutation-select controller for MCY
//
// NUM_CH independent channels, each with a staged {idx, delay, len} set written
// through one shared valid/ready config port. A start pulse opens a window:
// WAIT for `delay` cycles, ACTIVE for `len` cycles (0 = until abort), then DONE.
// mutsel_o carries the staged index only while the channel is ACTIVE.
//
// Optional build macro MCY_MUTSEL_TRIGGER_EN: adds trig_i, and the WAIT delay
// then counts trigger events instead of clock cycles.
module mcy_mutsel_ctrl #(
  parameter int MUTSEL_W = 8,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [CH_W-1:0]              cfg_ch_i,
  input  logic [MUTSEL_W-1:0]          cfg_idx_i,
  input  logic [CNT_W-1:0]             cfg_delay_i,
  input  logic [CNT_W-1:0]             cfg_len_i,
  input  logic [NUM_CH-1:0]            start_i,
  input  logic [NUM_CH-1:0]            abort_i,
`ifdef MCY_MUTSEL_TRIGGER_EN
  input  logic [NUM_CH-1:0]            trig_i,
`endif
  output logic [NUM_CH*MUTSEL_W-1:0]   mutsel_o,
  output logic [NUM_CH-1:0]            active_o,
  output logic [NUM_CH-1:0]            busy_o,
  output logic [NUM_CH-1:0]            done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Per-channel state. The run_* copies are latched at start so that a config
  // write accepted on the start edge only affects the following window.
  state_e              state_q   [NUM_CH];
  logic [MUTSEL_W-1:0] idx_q     [NUM_CH];
  logic [CNT_W-1:0]    delay_q   [NUM_CH];
  logic [CNT_W-1:0]    len_q     [NUM_CH];
  logic [MUTSEL_W-1:0] run_idx_q [NUM_CH];
  logic [CNT_W-1:0]    run_len_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_q     [NUM_CH];
  logic [MUTSEL_W-1:0] mutsel_q  [NUM_CH];
  logic                done_q    [NUM_CH];

  logic [NUM_CH-1:0]   ch_free;
  logic [NUM_CH-1:0]   cfg_we;
  logic [NUM_CH-1:0]   wait_step;
  logic                cfg_ready;

  // Config port is ready when the addressed channel exists and is not running;
  // an out-of-range channel number matches no channel and therefore stalls.
  always_comb begin
    cfg_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((cfg_ch_i == CH_W'(c)) && ch_free[c]) begin
        cfg_ready = 1'b1;
      end
    end
    cfg_ready = cfg_ready & rst_ni;
  end

  assign cfg_ready_o = cfg_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    assign ch_free[c] = (state_q[c] == ST_IDLE) || (state_q[c] == ST_DONE);
    assign cfg_we[c]  = cfg_valid_i && cfg_ready && (cfg_ch_i == CH_W'(c));

`ifdef MCY_MUTSEL_TRIGGER_EN
    assign wait_step[c] = trig_i[c];
`else
    assign wait_step[c] = 1'b1;
`endif

    // Channel FSM: staging, window sequencing and registered mutsel/done.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q[c]   <= ST_IDLE;
        idx_q[c]     <= '0;
        delay_q[c]   <= '0;
        len_q[c]     <= '0;
        run_idx_q[c] <= '0;
        run_len_q[c] <= '0;
        cnt_q[c]     <= '0;
        mutsel_q[c]  <= '0;
        done_q[c]    <= 1'b0;
      end else begin
        done_q[c] <= 1'b0;

        if (cfg_we[c]) begin
          idx_q[c]   <= cfg_idx_i;
          delay_q[c] <= cfg_delay_i;
          len_q[c]   <= cfg_len_i;
        end

        if (abort_i[c]) begin
          // Abort wins over start and expiry; no done pulse.
          state_q[c]  <= ST_IDLE;
          cnt_q[c]    <= '0;
          mutsel_q[c] <= '0;
        end else begin
          unique case (state_q[c])
            ST_IDLE, ST_DONE: begin
              if (start_i[c]) begin
                run_idx_q[c] <= idx_q[c];
                run_len_q[c] <= len_q[c];
                if (delay_q[c] == '0) begin
                  state_q[c]  <= ST_ACTIVE;
                  cnt_q[c]    <= len_q[c];
                  mutsel_q[c] <= idx_q[c];
                end else begin
                  state_q[c] <= ST_WAIT;
                  cnt_q[c]   <= delay_q[c];
                end
              end
            end
            ST_WAIT: begin
              // The transition fires on the step taken at count 1, so the
              // full counter range is usable without wrap.
              if (wait_step[c]) begin
                if (cnt_q[c] == CNT_W'(1)) begin
                  state_q[c]  <= ST_ACTIVE;
                  cnt_q[c]    <= run_len_q[c];
                  mutsel_q[c] <= run_idx_q[c];
                end else begin
                  cnt_q[c] <= cnt_q[c] - CNT_W'(1);
                end
              end
            end
            ST_ACTIVE: begin
              // A zero length holds the window open until abort.
              if (run_len_q[c] != '0) begin
                if (cnt_q[c] == CNT_W'(1)) begin
                  state_q[c]  <= ST_DONE;
                  cnt_q[c]    <= '0;
                  mutsel_q[c] <= '0;
                  done_q[c]   <= 1'b1;
                end else begin
                  cnt_q[c] <= cnt_q[c] - CNT_W'(1);
                end
              end
            end
            default: begin
              state_q[c] <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign mutsel_o[c*MUTSEL_W +: MUTSEL_W] = mutsel_q[c];
    assign active_o[c] = (state_q[c] == ST_ACTIVE);
    assign busy_o[c]   = (state_q[c] == ST_WAIT) || (state_q[c] == ST_ACTIVE);
    assign done_o[c]   = done_q[c];
  end

endmodule
